// File: rtl/wb_stage_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional WB_RESULT_MUX_EN adds a combinational write-back result mux (result_out).
module wb_stage_skid_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int RSRC_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       alu_result_in,
  input  logic [XLEN-1:0]       read_data_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [XLEN-1:0]       pc_plus4_in,
  input  logic                  reg_write_in,
  input  logic [RSRC_W-1:0]     result_src_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_result_out,
  output logic [XLEN-1:0]       read_data_out,
  output logic [XLEN-1:0]       pc_plus4_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [RSRC_W-1:0]     result_src_out,
  output logic                  reg_write_out
`ifdef WB_RESULT_MUX_EN
  ,
  output logic [XLEN-1:0]       result_out
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       rdata;
    logic [XLEN-1:0]       pc4;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rw;
    logic [RSRC_W-1:0]     src;
  } entry_t;

  entry_t main_q;
  entry_t skid_q;
  entry_t in_e;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   drain;

  assign in_e = '{alu: alu_result_in, rdata: read_data_in, pc4: pc_plus4_in,
                  rd: rd_in, rw: reg_write_in, src: result_src_in};

  // Ready depends only on the skid flop, so out_ready never reaches in_ready.
  assign in_ready = !skid_valid && !reset;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        if (accept) skid_q <= in_e;
        else        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= in_e;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_e;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid      = main_valid;
  assign alu_result_out = main_q.alu;
  assign read_data_out  = main_q.rdata;
  assign pc_plus4_out   = main_q.pc4;
  assign rd_out         = main_q.rd;
  assign result_src_out = main_q.src;
  assign reg_write_out  = main_q.rw && main_valid;

`ifdef WB_RESULT_MUX_EN
  always_comb begin
    result_out = '0;
    if (!reset) begin
      case (main_q.src)
        RSRC_W'(0): result_out = main_q.alu;
        RSRC_W'(1): result_out = main_q.rdata;
        RSRC_W'(2): result_out = main_q.pc4;
        default:    result_out = '0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// Bench for wb_stage_skid_reg: per-cycle vector table plus a scoreboard of accepted entries.
module tb_wb_stage_skid_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] alu_result_in, read_data_in, pc_plus4_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic [1:0]  result_src_in;
  logic [31:0] alu_result_out, read_data_out, pc_plus4_out;
  logic [4:0]  rd_out;
  logic [1:0]  result_src_out;
  logic        reg_write_out;
`ifdef WB_RESULT_MUX_EN
  logic [31:0] result_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_skid_reg #(.XLEN(32), .REG_ADDR_W(5), .RSRC_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_in(alu_result_in), .read_data_in(read_data_in), .rd_in(rd_in),
    .pc_plus4_in(pc_plus4_in), .reg_write_in(reg_write_in), .result_src_in(result_src_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_out(alu_result_out), .read_data_out(read_data_out), .pc_plus4_out(pc_plus4_out),
    .rd_out(rd_out), .result_src_out(result_src_out), .reg_write_out(reg_write_out)
`ifdef WB_RESULT_MUX_EN
    , .result_out(result_out)
`endif
  );

  typedef struct {
    logic        rst, fl, iv;
    logic [4:0]  rd;
    logic [31:0] alu, rdat, pc4;
    logic [1:0]  src;
    logic        rw, ordy;
    logic        e_irdy, e_ov;
    logic [4:0]  e_rd;
    logic        chk_rd;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] alu, rdat, pc4;
    logic [1:0]  src;
    logic        rw;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [4:0] rd, input logic [31:0] alu,
                              input logic rw, input logic ordy, input logic e_irdy,
                              input logic e_ov, input logic [4:0] e_rd, input logic chk_rd);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.rd = rd; v.alu = alu;
    v.rdat = alu ^ 32'hA5A5_0000; v.pc4 = alu + 32'd4; v.src = rd[1:0];
    v.rw = rw; v.ordy = ordy; v.e_irdy = e_irdy; v.e_ov = e_ov;
    v.e_rd = e_rd; v.chk_rd = chk_rd;
    return v;
  endfunction

  // Drive one cycle of inputs, then check the state left behind by that edge.
  task automatic step(input vec_t v);
    reset = v.rst; flush = v.fl; in_valid = v.iv; rd_in = v.rd;
    alu_result_in = v.alu; read_data_in = v.rdat; pc_plus4_in = v.pc4;
    result_src_in = v.src; reg_write_in = v.rw; out_ready = v.ordy;
    @(posedge clk); #1;
    chk("in_ready", 32'(in_ready), 32'(v.e_irdy));
    chk("out_valid", 32'(out_valid), 32'(v.e_ov));
    if (v.chk_rd) chk("rd_out", 32'(rd_out), 32'(v.e_rd));
  endtask

  // Scoreboard: handshakes are evaluated mid-cycle with inputs stable for the next edge.
  always @(negedge clk) begin
    if (reset === 1'b1 || flush === 1'b1) begin
      sb_q.delete();
    end else begin
      if (out_valid !== 1'b1) chk("rw_gate", 32'(reg_write_out), 32'd0);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_out", 32'(rd_out), 32'h3F);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("sb_rd", 32'(rd_out), 32'(e.rd));
          chk("sb_alu", alu_result_out, e.alu);
          chk("sb_rdata", read_data_out, e.rdat);
          chk("sb_pc4", pc_plus4_out, e.pc4);
          chk("sb_src", 32'(result_src_out), 32'(e.src));
          chk("sb_rw", 32'(reg_write_out), 32'(e.rw));
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        sb_t n;
        n.rd = rd_in; n.alu = alu_result_in; n.rdat = read_data_in;
        n.pc4 = pc_plus4_in; n.src = result_src_in; n.rw = reg_write_in;
        sb_q.push_back(n);
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rd_in = '0; alu_result_in = '0; read_data_in = '0; pc_plus4_in = '0;
    reg_write_in = 1'b1; result_src_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu", alu_result_out, 32'd0);
    chk("rst_rdata", read_data_out, 32'd0);
    chk("rst_pc4", pc_plus4_out, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_src", 32'(result_src_out), 32'd0);
    chk("rst_rw", 32'(reg_write_out), 32'd0);
`ifdef WB_RESULT_MUX_EN
    chk("rst_result", result_out, 32'd0);
`endif
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Streaming rd=1..8 with out_ready=1
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 0, 1, 5'(i), 32'h100 + 32'(i), 1'(i % 2), 1, 1, 1, 5'(i), 1));
    // Bubbles with reg_write_in=1; data outputs keep last drained entry
    tbl.push_back(mk(0, 0, 0, 5'd0, 32'h0, 1, 1, 1, 0, 5'd8, 1));
    tbl.push_back(mk(0, 0, 0, 5'd0, 32'h0, 1, 1, 1, 0, 5'd8, 1));
    // Backpressure: A then B, held, then released
    tbl.push_back(mk(0, 0, 1, 5'd9,  32'h11, 1, 0, 1, 1, 5'd9, 1));
    tbl.push_back(mk(0, 0, 1, 5'd10, 32'h22, 1, 0, 0, 1, 5'd9, 1));
    tbl.push_back(mk(0, 0, 1, 5'd11, 32'h33, 1, 0, 0, 1, 5'd9, 1));
    tbl.push_back(mk(0, 0, 0, 5'd0,  32'h0,  0, 1, 1, 1, 5'd10, 1));
    tbl.push_back(mk(0, 0, 0, 5'd0,  32'h0,  0, 1, 1, 0, 5'd10, 1));
    // Full skid, then drain with in_valid held until accepted
    tbl.push_back(mk(0, 0, 1, 5'd12, 32'h44, 0, 0, 1, 1, 5'd12, 1));
    tbl.push_back(mk(0, 0, 1, 5'd13, 32'h55, 1, 0, 0, 1, 5'd12, 1));
    tbl.push_back(mk(0, 0, 1, 5'd14, 32'h66, 1, 1, 1, 1, 5'd13, 1));
    tbl.push_back(mk(0, 0, 1, 5'd14, 32'h66, 1, 1, 1, 1, 5'd14, 1));
    tbl.push_back(mk(0, 0, 0, 5'd0,  32'h0,  0, 1, 1, 0, 5'd14, 1));
    foreach (tbl[i]) step(tbl[i]);

    // Flush with both entries full and C offered
    step(mk(0, 0, 1, 5'd15, 32'h77, 1, 0, 1, 1, 5'd15, 1));
    step(mk(0, 0, 1, 5'd16, 32'h88, 1, 0, 0, 1, 5'd15, 1));
    step(mk(0, 1, 1, 5'd20, 32'hCC, 1, 0, 1, 0, 5'd15, 1));
    chk("flush_rw", 32'(reg_write_out), 32'd0);
    step(mk(0, 0, 0, 5'd0, 32'h0, 0, 1, 1, 0, 5'd15, 1));
    // Flush discarding an entry that would have been accepted
    step(mk(0, 0, 1, 5'd17, 32'h99, 1, 0, 1, 1, 5'd17, 1));
    step(mk(0, 1, 1, 5'd18, 32'hAA, 1, 0, 1, 0, 5'd17, 1));
    step(mk(0, 0, 0, 5'd0, 32'h0, 0, 1, 1, 0, 5'd17, 1));

    // Reset mid-stream with both entries full
    step(mk(0, 0, 1, 5'd19, 32'hBB, 1, 0, 1, 1, 5'd19, 1));
    step(mk(0, 0, 1, 5'd22, 32'hDD, 1, 0, 0, 1, 5'd19, 1));
    step(mk(1, 0, 1, 5'd23, 32'hEE, 1, 1, 0, 0, 5'd0, 1));
    chk("mid_rst_alu", alu_result_out, 32'd0);
    chk("mid_rst_rw", 32'(reg_write_out), 32'd0);
    step(mk(0, 0, 0, 5'd0, 32'h0, 0, 1, 1, 0, 5'd0, 1));

`ifdef WB_RESULT_MUX_EN
    for (int s = 0; s < 4; s++) begin
      vec_t v;
      logic [31:0] exp_res;
      v = mk(0, 0, 1, 5'(s + 1), 32'hA, 1, 1, 1, 1, 5'(s + 1), 1);
      v.rdat = 32'hB; v.pc4 = 32'hC; v.src = 2'(s);
      step(v);
      exp_res = (s == 0) ? 32'hA : (s == 1) ? 32'hB : (s == 2) ? 32'hC : 32'h0;
      chk("result_out", result_out, exp_res);
    end
`endif

    step(mk(0, 0, 1, 5'd21, 32'h1234, 1, 1, 1, 1, 5'd21, 1));
    step(mk(0, 0, 0, 5'd0, 32'h0, 0, 1, 1, 0, 5'd21, 1));
    step(mk(0, 0, 0, 5'd0, 32'h0, 0, 1, 1, 0, 5'd21, 1));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
